// File: rtl/poly_eval_arbiter.sv
// Two-requester round-robin scheduler evaluating y = a*x^2 + b*x + c on one
// shared add/multiply ALU using a four-step Horner schedule (mod 2^WIDTH).
module poly_eval_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         req,
  input  logic [4*WIDTH-1:0] opnd0,
  input  logic [4*WIDTH-1:0] opnd1,
  output logic [1:0]         ack,
  output logic               busy,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  output logic               result_id
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration and operand capture happen here
  // C0    | a <= a*x
  // C1    | a <= a+b
  // C2    | a <= a*x
  // C3    | result <= a+c, result_valid pulses next cycle
  typedef enum logic [2:0] {IDLE, C0, C1, C2, C3} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, x_q, x_d;
  logic               gid_q, gid_d, last_q, last_d;
  logic [1:0]         ack_q, ack_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               result_id_q, result_id_d;
  logic               grant;
  logic [4*WIDTH-1:0] opnd_sel;

  logic               alu_mul;
  logic [WIDTH-1:0]   alu_rhs;
  logic [WIDTH-1:0]   alu_out;

  // ALU operand selection depends on state only, keeping it out of the FSM loop
  always_comb begin
    alu_mul = (state_q == C0) || (state_q == C2);
    case (state_q)
      C1:      alu_rhs = b_q;
      C3:      alu_rhs = c_q;
      default: alu_rhs = x_q;
    endcase
    alu_out = alu_mul ? (a_q * alu_rhs) : (a_q + alu_rhs);
  end

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    c_d            = c_q;
    x_d            = x_q;
    gid_d          = gid_q;
    last_d         = last_q;
    ack_d          = 2'b00;
    result_d       = result_q;
    result_valid_d = 1'b0;
    result_id_d    = result_id_q;
    grant          = (req == 2'b11) ? ~last_q : req[1];
    opnd_sel       = grant ? opnd1 : opnd0;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          {a_d, b_d, c_d, x_d} = opnd_sel;
          gid_d   = grant;
          last_d  = grant;
          ack_d   = grant ? 2'b10 : 2'b01;
          state_d = C0;
        end
      end
      C0: begin
        a_d     = alu_out;
        state_d = C1;
      end
      C1: begin
        a_d     = alu_out;
        state_d = C2;
      end
      C2: begin
        a_d     = alu_out;
        state_d = C3;
      end
      C3: begin
        result_d       = alu_out;
        result_id_d    = gid_q;
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      c_q            <= '0;
      x_q            <= '0;
      gid_q          <= 1'b0;
      last_q         <= 1'b1;
      ack_q          <= 2'b00;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      c_q            <= c_d;
      x_q            <= x_d;
      gid_q          <= gid_d;
      last_q         <= last_d;
      ack_q          <= ack_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign ack          = ack_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Bench for poly_eval_arbiter: a job-level scheduling model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_poly_eval_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] opnd0 = '0;
  logic [31:0] opnd1 = '0;
  logic [1:0]  ack;
  logic        busy;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_id;

  always #5 clk = ~clk;

  poly_eval_arbiter #(.WIDTH(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req          (req),
    .opnd0        (opnd0),
    .opnd1        (opnd1),
    .ack          (ack),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] poly(logic [31:0] o);
    int a, b, c, x;
    a = int'(o[31:24]);
    b = int'(o[23:16]);
    c = int'(o[15:8]);
    x = int'(o[7:0]);
    return 8'((a * x * x + b * x + c) % 256);
  endfunction

  // Job-level model: a granted job occupies the datapath for cycles T+1..T+4,
  // acks at T+1 and publishes its polynomial value at T+5.
  int         cyc = 0;
  int         idle_at = 0;
  int         ack_at = -1;
  int         done_at = -1;
  logic [1:0] m_ack_val = 2'b00;
  logic       m_last = 1'b1;
  logic       m_g;
  logic [7:0] job_y = '0;
  logic       job_id = 1'b0;
  logic [7:0] e_result = '0;
  logic       e_id = 1'b0;
  bit         model_ok = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      cyc++;
      idle_at  = cyc;
      ack_at   = -1;
      done_at  = -1;
      m_last   = 1'b1;
      e_result = '0;
      e_id     = 1'b0;
      model_ok = 1;
    end else begin
      if (cyc >= idle_at && req != 2'b00) begin
        m_g       = (req == 2'b11) ? !m_last : req[1];
        m_last    = m_g;
        job_id    = m_g;
        job_y     = poly(m_g ? opnd1 : opnd0);
        m_ack_val = m_g ? 2'b10 : 2'b01;
        ack_at    = cyc + 1;
        idle_at   = cyc + 5;
        done_at   = cyc + 5;
      end
      cyc++;
      if (cyc == done_at) begin
        e_result = job_y;
        e_id     = job_id;
      end
    end
  end

  int         ack_cyc_q[$];
  logic [1:0] ack_val_q[$];
  int         rv_cyc_q[$];
  logic [7:0] rv_y_q[$];
  logic       rv_id_q[$];

  always @(negedge clk) begin
    if (model_ok) begin
      chk("ack", int'(ack), (cyc == ack_at) ? int'(m_ack_val) : 0);
      chk("busy", int'(busy), (cyc < idle_at) ? 1 : 0);
      chk("result_valid", int'(result_valid), (cyc == done_at) ? 1 : 0);
      chk("result", int'(result), int'(e_result));
      chk("result_id", int'(result_id), int'(e_id));
    end
    if (ack != 2'b00) begin
      ack_cyc_q.push_back(cyc);
      ack_val_q.push_back(ack);
    end
    if (result_valid) begin
      rv_cyc_q.push_back(cyc);
      rv_y_q.push_back(result);
      rv_id_q.push_back(result_id);
    end
  end

  bit drop_en = 1;

  task automatic step();
    @(negedge clk);
    #1;
    if (drop_en) req = req & ~ack;
  endtask

  task automatic clear_logs();
    ack_cyc_q.delete();
    ack_val_q.delete();
    rv_cyc_q.delete();
    rv_y_q.delete();
    rv_id_q.delete();
  endtask

  task automatic wait_rv(int n, int limit);
    for (int i = 0; i < limit; i++) begin
      if (rv_y_q.size() >= n) break;
      step();
    end
    if (rv_y_q.size() < n) chk("timeout_result", rv_y_q.size(), n);
  endtask

  task automatic wait_ack(int n, int limit);
    for (int i = 0; i < limit; i++) begin
      if (ack_cyc_q.size() >= n) break;
      step();
    end
    if (ack_cyc_q.size() < n) chk("timeout_ack", ack_cyc_q.size(), n);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    step();
    step();
    resetn = 1'b1;
    step();
    chk("reset_result", int'(result), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ack", int'(ack), 0);
    chk("reset_rv", int'(result_valid), 0);

    // basic: 2*25 + 3*5 + 4 = 69
    clear_logs();
    opnd0 = {8'd2, 8'd3, 8'd4, 8'd5};
    req = 2'b01;
    wait_rv(1, 20);
    if (rv_y_q.size() >= 1 && ack_cyc_q.size() >= 1) begin
      chk("basic_y", int'(rv_y_q[0]), 69);
      chk("basic_id", int'(rv_id_q[0]), 0);
      chk("basic_ack", int'(ack_val_q[0]), 1);
      chk("basic_latency", rv_cyc_q[0] - ack_cyc_q[0], 4);
    end

    // overflow: every intermediate wraps to 0, result = c = 1
    clear_logs();
    opnd1 = {8'd16, 8'd0, 8'd1, 8'd16};
    req = 2'b10;
    wait_rv(1, 20);
    if (rv_y_q.size() >= 1) begin
      chk("ovf_y", int'(rv_y_q[0]), 1);
      chk("ovf_id", int'(rv_id_q[0]), 1);
    end

    // tie after reset: requester 0 first, then 1 at T+6
    do_reset();
    clear_logs();
    opnd0 = {8'd1, 8'd1, 8'd1, 8'd1};
    opnd1 = {8'd0, 8'd0, 8'd7, 8'd3};
    req = 2'b11;
    wait_rv(2, 40);
    if (rv_y_q.size() >= 2 && ack_cyc_q.size() >= 2) begin
      chk("tie_y0", int'(rv_y_q[0]), 3);
      chk("tie_id0", int'(rv_id_q[0]), 0);
      chk("tie_y1", int'(rv_y_q[1]), 7);
      chk("tie_id1", int'(rv_id_q[1]), 1);
      chk("tie_ack_gap", ack_cyc_q[1] - ack_cyc_q[0], 5);
    end
    repeat (12) step();
    chk("tie_no_dup_rv", rv_y_q.size(), 2);
    chk("tie_no_dup_ack", ack_cyc_q.size(), 2);

    // round-robin with req held: ids 0,1,0,1
    do_reset();
    clear_logs();
    drop_en = 0;
    opnd0 = {8'd1, 8'd2, 8'd3, 8'd4};
    opnd1 = {8'd3, 8'd0, 8'd0, 8'd2};
    req = 2'b11;
    wait_ack(4, 40);
    req = 2'b00;
    wait_rv(4, 40);
    repeat (8) step();
    chk("rr_count", rv_y_q.size(), 4);
    if (rv_y_q.size() >= 4 && ack_cyc_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_id", int'(rv_id_q[i]), i % 2);
        chk("rr_y", int'(rv_y_q[i]), (i % 2 == 0) ? 27 : 12);
        chk("rr_ack", int'(ack_val_q[i]), (i % 2 == 0) ? 1 : 2);
        if (i > 0) chk("rr_gap", ack_cyc_q[i] - ack_cyc_q[i-1], 5);
      end
    end
    drop_en = 1;

    // reset in C2 discards the job
    clear_logs();
    opnd0 = {8'd2, 8'd3, 8'd4, 8'd5};
    req = 2'b01;
    wait_ack(1, 20);
    step();
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_rv", int'(result_valid), 0);
    repeat (10) step();
    chk("midrst_no_rv", rv_y_q.size(), 0);
    req = 2'b01;
    wait_rv(1, 20);
    if (rv_y_q.size() >= 1) chk("midrst_after_y", int'(rv_y_q[0]), 69);

    // operand changes after grant do not affect the job
    clear_logs();
    opnd0 = {8'd2, 8'd3, 8'd4, 8'd5};
    req = 2'b01;
    wait_ack(1, 20);
    opnd0 = {8'd9, 8'd9, 8'd9, 8'd9};
    wait_rv(1, 20);
    if (rv_y_q.size() >= 1) chk("stable_y", int'(rv_y_q[0]), 69);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_eval_arbiter.md
# poly_eval_arbiter

Shared-datapath scheduler for quadratic evaluation y = a·x² + b·x + c. Two independent requesters submit operand sets over a req/ack handshake. A round-robin arbiter grants one requester at a time and sequences a single shared add/multiply ALU through a fixed 4-step Horner schedule. The result is returned tagged with the requester id. It sits between board-level input logic (switch/key capture) and the result display path.

## Interface
- WIDTH, 8, operand/result width; all arithmetic is mod 2^WIDTH
- clk  in  1  system clock, all state on posedge
- resetn  in  1  synchronous, active-low reset
- req  in  2  req[i] high = requester i has an operand set pending; held until ack[i]
- opnd0  in  4·WIDTH  requester 0 operands, packed {a,b,c,x} (a in MSBs)
- opnd1  in  4·WIDTH  requester 1 operands, same packing
- ack  out  2  one-hot, one-cycle pulse; operands of that requester have been captured
- busy  out  1  high while an evaluation is in flight (states C0..C3)
- result  out  WIDTH  last computed y; held until overwritten
- result_valid  out  1  one-cycle pulse when result/result_id update
- result_id  out  1  requester index owning result

## Operation
- Internal registers: a, b, c, x (WIDTH each), gid (1 bit), last (1 bit, last granted id).
- One shared ALU: op 0 = add, op 1 = multiply. Product and sum are truncated to WIDTH.
- FSM states: IDLE, C0, C1, C2, C3.
  - IDLE: if req == 0, stay. Otherwise grant per arbitration, capture the granted opnd into a, b, c, x, set gid and last to the grant, pulse ack[grant] next cycle, and go to C0.
  - C0: a ← a·x. Go to C1.
  - C1: a ← a + b. Go to C2.
  - C2: a ← a·x. Go to C3.
  - C3: result ← a + c, result_id ← gid, result_valid pulses next cycle. Go to IDLE.
- Arbitration, evaluated only in IDLE:
  - Single request: grant it.
  - Both requests: grant ~last (round-robin).
- req is ignored outside IDLE. A req still high when the FSM returns to IDLE is treated as a new request. Requesters must drop req in the cycle ack is seen to avoid a duplicate job.
- Operand inputs are sampled only on the grant edge. Later changes have no effect on the in-flight job.
- Reset (any state, including mid-evaluation): state = IDLE, a/b/c/x = 0, result = 0, result_id = 0, result_valid = 0, ack = 0, gid = 0, last = 1 (requester 0 wins the first tie). An in-flight job is discarded and produces no result_valid.

## Timing
- Let T be the IDLE cycle in which req is sampled high.
- ack[grant] = 1 during T+1 only. busy = 1 during T+1..T+4.
- State sequence: C0 at T+1, C1 at T+2, C2 at T+3, C3 at T+4, IDLE at T+5.
- result, result_id and result_valid = 1 are visible during T+5 (latency 5 cycles from the sampling edge).
- In T+5 (IDLE), a new request can be sampled, giving its ack at T+6. Peak throughput is one job per 5 cycles.
- result_valid and ack are registered, glitch-free, and never high for two consecutive cycles for the same job.
- busy = 0 and ack = 0 in every IDLE cycle.

## Test plan
- Basic: after reset, req = 01, opnd0 = {2,3,4,5}.
  - Expected: ack = 01 at T+1; busy high T+1..T+4; result = 69 (0x45), result_id = 0, result_valid pulse at T+5.
- Overflow: req = 10, opnd1 = {16,0,1,16}.
  - Expected: intermediates 0, 0, 0; result = 1, result_id = 1. Confirms mod-256 truncation at every step.
- Tie and fairness: after reset, req = 11 held, each requester dropping req on its ack; opnd0 = {1,1,1,1}, opnd1 = {0,0,7,3}.
  - Expected: first result 3 with id 0, second result 7 with id 1; second ack at T+6; no duplicate jobs.
- Round-robin: hold req = 11 continuously for 4 jobs.
  - Expected: result_id sequence 0, 1, 0, 1; one ack per 5 cycles, alternating.
- Reset mid-operation: start a job, assert resetn = 0 in C2 for one cycle.
  - Expected: next cycle in IDLE, result = 0, busy = 0, no result_valid pulse; a new job afterward computes correctly.
- Operand stability: change opnd0 during C0..C3 of a running job.
  - Expected: result reflects the operands captured at grant only.
